// File: rtl/m68k_bus_xactor_if.sv
// Command/response stream plus 68010 bus pins bundled for m68k_bus_xactor.
// Latency: none, this is a signal bundle only.
// Backpressure: cmd_valid/cmd_ready handshake; rsp_valid is a one-cycle pulse with no ready.
// Ports: master = transactor side, slave = command source plus board bus model.
interface m68k_bus_xactor_if #(
  parameter int ADDR_W = 23
);
  // command stream
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rw;
  logic              cmd_size;
  logic [ADDR_W:0]   cmd_addr;
  logic [2:0]        cmd_fc;
  logic [15:0]       cmd_wdata;
  // response stream
  logic              rsp_valid;
  logic [15:0]       rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              rsp_addrerr;
  logic              rsp_vpa;
  // 68010 bus
  logic [ADDR_W-1:0] addr;
  logic [2:0]        fc;
  logic              as_n;
  logic              uds_n;
  logic              lds_n;
  logic              rw_n;
  logic              bus_oe;
  logic [15:0]       dout;
  logic              dout_oe;
  logic [15:0]       din;
  logic              dtack_n;
  logic              berr_n;
  logic              vpa_n;
  logic              br_n;
  logic              bgack_n;
  logic              bg_n;

  modport master (
    input  cmd_valid, cmd_rw, cmd_size, cmd_addr, cmd_fc, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout, rsp_addrerr, rsp_vpa,
    output addr, fc, as_n, uds_n, lds_n, rw_n, bus_oe, dout, dout_oe, bg_n,
    input  din, dtack_n, berr_n, vpa_n, br_n, bgack_n
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_size, cmd_addr, cmd_fc, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout, rsp_addrerr, rsp_vpa,
    input  addr, fc, as_n, uds_n, lds_n, rw_n, bus_oe, dout, dout_oe, bg_n,
    output din, dtack_n, berr_n, vpa_n, br_n, bgack_n
  );
endinterface

// File: rtl/m68k_bus_xactor.sv
// 68010-style bus master: turns valid/ready commands into AS/UDS/LDS/DTACK bus cycles.
// Latency: SETUP cycles to AS, then until DTACK/BERR/VPA (after SYNC_STAGES) or TIMEOUT; response in END.
// Backpressure: cmd_ready only in IDLE with no bus request pending; rsp_valid cannot be stalled.
// Ports: clk40/reset (sync, active high), bus = m68k_bus_xactor_if.master (command, response, bus pins).
module m68k_bus_xactor #(
  parameter int ADDR_W      = 23,
  parameter int SETUP       = 1,
  parameter int TIMEOUT     = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk40,
  input  logic              reset,
  m68k_bus_xactor_if.master bus
);
  localparam int SC_W = (SETUP > 1) ? $clog2(SETUP) : 1;
  localparam int TW   = $clog2(TIMEOUT + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_STROBE, S_WAIT, S_END, S_RECOVER, S_GRANT
  } state_t;

  state_t            r_state;
  logic              r_as_n, r_uds_n, r_lds_n, r_rw_n, r_bg_n, r_bus_oe, r_dout_oe;
  logic              r_use_u, r_use_l;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_fc;
  logic [15:0]       r_dout;
  logic              r_rsp_valid, r_rsp_err, r_rsp_timeout, r_rsp_addrerr, r_rsp_vpa;
  logic [15:0]       r_rsp_rdata;
  logic [SC_W-1:0]   r_setup_cnt;
  logic [TW-1:0]     r_tmr;

  // Asynchronous bus inputs, order {dtack, berr, vpa, br, bgack}; idle high.
  logic [4:0] w_raw, w_sync;
  assign w_raw = {bus.dtack_n, bus.berr_n, bus.vpa_n, bus.br_n, bus.bgack_n};

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_sync = w_raw;
    end else begin : g_sync
      logic [4:0] r_pipe [SYNC_STAGES];
      always_ff @(posedge clk40) begin
        if (reset) begin
          for (int i = 0; i < SYNC_STAGES; i++) r_pipe[i] <= '1;
        end else begin
          r_pipe[0] <= w_raw;
          for (int i = 1; i < SYNC_STAGES; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end
      assign w_sync = r_pipe[SYNC_STAGES-1];
    end
  endgenerate

  logic w_dtack_n, w_berr_n, w_vpa_n, w_br_n, w_bgack_n;
  assign {w_dtack_n, w_berr_n, w_vpa_n, w_br_n, w_bgack_n} = w_sync;

  // Timer holds the number of cycles elapsed since STROBE entry, current cycle included.
  logic w_to_hit, w_term, w_is_to;
  assign w_to_hit = (TIMEOUT != 0) && (r_tmr == TW'(TIMEOUT));
  assign w_term   = !w_berr_n || !w_dtack_n || !w_vpa_n || w_to_hit;
  assign w_is_to  = w_berr_n && w_dtack_n && w_vpa_n;

  always_ff @(posedge clk40) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_as_n        <= 1'b1;
      r_uds_n       <= 1'b1;
      r_lds_n       <= 1'b1;
      r_rw_n        <= 1'b1;
      r_bg_n        <= 1'b1;
      r_bus_oe      <= 1'b1;
      r_dout_oe     <= 1'b0;
      r_use_u       <= 1'b0;
      r_use_l       <= 1'b0;
      r_addr        <= '0;
      r_fc          <= '0;
      r_dout        <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_addrerr <= 1'b0;
      r_rsp_vpa     <= 1'b0;
      r_rsp_rdata   <= '0;
      r_setup_cnt   <= '0;
      r_tmr         <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_br_n) begin
            // A pending bus request wins over a same-cycle command.
            r_state  <= S_GRANT;
            r_bg_n   <= 1'b0;
            r_bus_oe <= 1'b0;
          end else if (bus.cmd_valid) begin
            if (bus.cmd_size && bus.cmd_addr[0]) begin
              // Odd word access: answer immediately, no bus cycle.
              r_rsp_valid   <= 1'b1;
              r_rsp_err     <= 1'b1;
              r_rsp_addrerr <= 1'b1;
              r_rsp_timeout <= 1'b0;
              r_rsp_vpa     <= 1'b0;
            end else begin
              r_state     <= S_ADDR;
              r_addr      <= bus.cmd_addr[ADDR_W:1];
              r_fc        <= bus.cmd_fc;
              r_rw_n      <= bus.cmd_rw;
              r_dout      <= bus.cmd_wdata;
              r_dout_oe   <= !bus.cmd_rw;
              r_use_u     <= bus.cmd_size || !bus.cmd_addr[0];
              r_use_l     <= bus.cmd_size ||  bus.cmd_addr[0];
              r_setup_cnt <= '0;
            end
          end
        end
        S_ADDR: begin
          if (r_setup_cnt == SC_W'(SETUP - 1)) begin
            r_state <= S_STROBE;
            r_as_n  <= 1'b0;
            r_tmr   <= TW'(1);
            if (r_rw_n) begin
              r_uds_n <= !r_use_u;
              r_lds_n <= !r_use_l;
            end
          end else begin
            r_setup_cnt <= r_setup_cnt + SC_W'(1);
          end
        end
        S_STROBE: begin
          // Writes qualify the lanes a cycle after AS so data is stable first.
          r_state <= S_WAIT;
          r_tmr   <= r_tmr + TW'(1);
          if (!r_rw_n) begin
            r_uds_n <= !r_use_u;
            r_lds_n <= !r_use_l;
          end
        end
        S_WAIT: begin
          r_tmr <= r_tmr + TW'(1);
          if (w_term) begin
            r_state       <= S_END;
            r_as_n        <= 1'b1;
            r_uds_n       <= 1'b1;
            r_lds_n       <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= !w_berr_n || w_is_to;
            r_rsp_timeout <= w_is_to;
            r_rsp_vpa     <= w_berr_n && w_dtack_n && !w_vpa_n;
            r_rsp_addrerr <= 1'b0;
            if (r_rw_n && !w_is_to) r_rsp_rdata <= bus.din;
          end
        end
        S_END: begin
          r_state   <= S_RECOVER;
          r_rw_n    <= 1'b1;
          r_dout_oe <= 1'b0;
        end
        S_RECOVER: begin
          // Hold off until the slave has released every termination line.
          if (w_dtack_n && w_berr_n && w_vpa_n) r_state <= S_IDLE;
        end
        S_GRANT: begin
          if (!w_bgack_n) r_bg_n <= 1'b1;
          if (w_br_n && w_bgack_n) begin
            r_state  <= S_IDLE;
            r_bg_n   <= 1'b1;
            r_bus_oe <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = (r_state == S_IDLE) && w_br_n && !reset;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign bus.rsp_addrerr = r_rsp_addrerr;
  assign bus.rsp_vpa     = r_rsp_vpa;
  assign bus.addr        = r_addr;
  assign bus.fc          = r_fc;
  assign bus.as_n        = r_as_n;
  assign bus.uds_n       = r_uds_n;
  assign bus.lds_n       = r_lds_n;
  assign bus.rw_n        = r_rw_n;
  assign bus.bus_oe      = r_bus_oe;
  assign bus.dout        = r_dout;
  assign bus.dout_oe     = r_dout_oe;
  assign bus.bg_n        = r_bg_n;
endmodule

// File: tb/tb_m68k_bus_xactor.sv
// Bench for m68k_bus_xactor: directed scenarios then random commands against a transaction-level model.
// Latency: checks strobe timing, timeout latency and response contents per transaction.
// Backpressure: waits on cmd_ready with bounded loops; a built-in slave answers AS with DTACK/BERR/VPA.
module tb_m68k_bus_xactor;
  localparam int ADDR_W  = 23;
  localparam int SETUP   = 1;
  localparam int TIMEOUT = 16;
  localparam int SYNC    = 2;
  localparam int K_DTACK = 0, K_BERR = 1, K_VPA = 2, K_NONE = 3, K_BOTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  m68k_bus_xactor_if #(.ADDR_W(ADDR_W)) bif ();

  m68k_bus_xactor #(.ADDR_W(ADDR_W), .SETUP(SETUP), .TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC)) dut (
    .clk40 (clk),
    .reset (reset),
    .bus   (bif)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] m_rdata;   // model of rsp_rdata: last din captured by a non-timeout read

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Issues one command, plays the slave, checks the whole cycle.
  task automatic do_xact(input bit rw, input bit sz, input logic [23:0] a, input logic [2:0] f,
                         input logic [15:0] wd, input int kind, input int dly, input logic [15:0] rd);
    bit use_u, use_l, aerr;
    int n, c, got;
    aerr  = sz && a[0];
    use_u = sz || !a[0];
    use_l = sz ||  a[0];
    bif.cmd_rw = rw; bif.cmd_size = sz; bif.cmd_addr = a; bif.cmd_fc = f; bif.cmd_wdata = wd;
    bif.cmd_valid = 1'b1;
    n = 0;
    while (!bif.cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("cmd_ready", 32'(bif.cmd_ready), 32'd1);
    @(negedge clk);
    bif.cmd_valid = 1'b0;
    if (aerr) begin
      chk("ae_rsp_valid", 32'(bif.rsp_valid), 32'd1);
      chk("ae_err", 32'(bif.rsp_err), 32'd1);
      chk("ae_addrerr", 32'(bif.rsp_addrerr), 32'd1);
      chk("ae_timeout", 32'(bif.rsp_timeout), 32'd0);
      chk("ae_as_n", 32'(bif.as_n), 32'd1);
      chk("ae_rdata", 32'(bif.rsp_rdata), 32'(m_rdata));
      @(negedge clk);
      chk("ae_pulse", 32'(bif.rsp_valid), 32'd0);
      chk("ae_as_n2", 32'(bif.as_n), 32'd1);
      return;
    end
    chk("addr", 32'(bif.addr), 32'(a[23:1]));
    chk("fc", 32'(bif.fc), 32'(f));
    chk("addr_rw_n", 32'(bif.rw_n), 32'(rw));
    chk("addr_dout_oe", 32'(bif.dout_oe), 32'(!rw));
    chk("addr_as_n", 32'(bif.as_n), 32'd1);
    if (!rw) chk("dout", 32'(bif.dout), 32'(wd));
    repeat (SETUP) @(negedge clk);
    chk("strobe_as_n", 32'(bif.as_n), 32'd0);
    chk("strobe_uds_n", 32'(bif.uds_n), rw ? 32'(!use_u) : 32'd1);
    chk("strobe_lds_n", 32'(bif.lds_n), rw ? 32'(!use_l) : 32'd1);
    bif.din = rd;
    c = 0; got = -1;
    while (c < 40) begin
      if (c == dly) begin
        case (kind)
          K_DTACK: bif.dtack_n = 1'b0;
          K_BERR:  bif.berr_n  = 1'b0;
          K_VPA:   bif.vpa_n   = 1'b0;
          K_BOTH:  begin bif.berr_n = 1'b0; bif.dtack_n = 1'b0; end
          default: ;
        endcase
      end
      @(negedge clk);
      c++;
      if (c == 1 && !rw) begin
        chk("wr_uds_n", 32'(bif.uds_n), 32'(!use_u));
        chk("wr_lds_n", 32'(bif.lds_n), 32'(!use_l));
      end
      if (bif.rsp_valid) begin got = c; break; end
    end
    chk("rsp_seen", 32'(got >= 0), 32'd1);
    if (kind == K_NONE) chk("timeout_latency", 32'(got), 32'(TIMEOUT));
    if (rw && kind != K_NONE) m_rdata = rd;
    chk("rsp_err", 32'(bif.rsp_err), 32'(kind == K_BERR || kind == K_NONE || kind == K_BOTH));
    chk("rsp_timeout", 32'(bif.rsp_timeout), 32'(kind == K_NONE));
    chk("rsp_vpa", 32'(bif.rsp_vpa), 32'(kind == K_VPA));
    chk("rsp_addrerr", 32'(bif.rsp_addrerr), 32'd0);
    chk("rsp_rdata", 32'(bif.rsp_rdata), 32'(m_rdata));
    chk("end_strobes", 32'({bif.as_n, bif.uds_n, bif.lds_n}), 32'h7);
    chk("end_rw_n", 32'(bif.rw_n), 32'(rw));
    chk("end_dout_oe", 32'(bif.dout_oe), 32'(!rw));
    bif.dtack_n = 1'b1; bif.berr_n = 1'b1; bif.vpa_n = 1'b1;
    @(negedge clk);
    chk("rec_pulse", 32'(bif.rsp_valid), 32'd0);
    chk("rec_rw_n", 32'(bif.rw_n), 32'd1);
    chk("rec_dout_oe", 32'(bif.dout_oe), 32'd0);
    n = 0;
    while (!bif.cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk("back_to_idle", 32'(bif.cmd_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, seen;
    int r, kind;
    m_rdata = '0;
    bif.cmd_valid = 1'b0; bif.cmd_rw = 1'b1; bif.cmd_size = 1'b1; bif.cmd_addr = '0;
    bif.cmd_fc = '0; bif.cmd_wdata = '0; bif.din = '0;
    bif.dtack_n = 1'b1; bif.berr_n = 1'b1; bif.vpa_n = 1'b1; bif.br_n = 1'b1; bif.bgack_n = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_strobes", 32'({bif.as_n, bif.uds_n, bif.lds_n, bif.rw_n, bif.bg_n}), 32'h1f);
    chk("rst_bus_oe", 32'(bif.bus_oe), 32'd1);
    chk("rst_dout_oe", 32'(bif.dout_oe), 32'd0);
    chk("rst_rsp", 32'({bif.rsp_valid, bif.rsp_err, bif.rsp_timeout, bif.rsp_addrerr, bif.rsp_vpa}), 32'd0);
    chk("rst_cmd_ready", 32'(bif.cmd_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(bif.cmd_ready), 32'd1);

    // word read, DTACK three cycles after AS
    do_xact(1'b1, 1'b1, 24'h000400, 3'd5, 16'h0000, K_DTACK, 3, 16'h4AFC);
    // byte write to odd address: lower lane only
    do_xact(1'b0, 1'b0, 24'h000401, 3'd1, 16'h5A5A, K_DTACK, 1, 16'h0000);
    // byte read even address: upper lane only
    do_xact(1'b1, 1'b0, 24'h000402, 3'd5, 16'h0000, K_DTACK, 0, 16'h1357);
    // odd word access
    do_xact(1'b1, 1'b1, 24'h000003, 3'd5, 16'h0000, K_DTACK, 0, 16'h0000);
    // no response: timeout, rdata unchanged
    do_xact(1'b1, 1'b1, 24'h001000, 3'd6, 16'h0000, K_NONE, 0, 16'hDEAD);
    // BERR and DTACK together: plain bus error
    do_xact(1'b1, 1'b1, 24'h001002, 3'd6, 16'h0000, K_BOTH, 2, 16'hBEEF);
    // VPA terminated read
    do_xact(1'b1, 1'b1, 24'h00fffe, 3'd7, 16'h0000, K_VPA, 4, 16'h00A5);

    // bus request colliding with a command
    bif.br_n = 1'b0;
    repeat (SYNC) @(negedge clk);
    chk("grant_ready_low", 32'(bif.cmd_ready), 32'd0);
    bif.cmd_valid = 1'b1; bif.cmd_rw = 1'b1; bif.cmd_size = 1'b1;
    bif.cmd_addr = 24'h000800; bif.cmd_fc = 3'd6;
    @(negedge clk);
    chk("grant_bg_n", 32'(bif.bg_n), 32'd0);
    chk("grant_bus_oe", 32'(bif.bus_oe), 32'd0);
    chk("grant_ready", 32'(bif.cmd_ready), 32'd0);
    chk("grant_as_n", 32'(bif.as_n), 32'd1);
    bif.bgack_n = 1'b0; bif.br_n = 1'b1;
    n = 0;
    while (!bif.bg_n && n < 10) begin @(negedge clk); n++; end
    chk("bg_release", 32'(bif.bg_n), 32'd1);
    chk("bgack_bus_oe", 32'(bif.bus_oe), 32'd0);
    chk("bgack_ready", 32'(bif.cmd_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("bgack_hold", 32'(bif.cmd_ready), 32'd0);
    bif.bgack_n = 1'b1;
    n = 0;
    while (!bif.cmd_ready && n < 10) begin @(negedge clk); n++; end
    chk("grant_exit_ready", 32'(bif.cmd_ready), 32'd1);
    chk("grant_exit_bus_oe", 32'(bif.bus_oe), 32'd1);
    do_xact(1'b1, 1'b1, 24'h000800, 3'd6, 16'h0000, K_DTACK, 2, 16'h6789);

    // reset in the middle of a read
    bif.cmd_rw = 1'b1; bif.cmd_size = 1'b1; bif.cmd_addr = 24'h000200; bif.cmd_fc = 3'd5;
    bif.cmd_valid = 1'b1;
    chk("mid_ready", 32'(bif.cmd_ready), 32'd1);
    @(negedge clk);
    bif.cmd_valid = 1'b0;
    repeat (SETUP + 3) @(negedge clk);
    chk("mid_wait_strobes", 32'({bif.as_n, bif.uds_n, bif.lds_n}), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_strobes", 32'({bif.as_n, bif.uds_n, bif.lds_n, bif.rw_n}), 32'hf);
    chk("mid_rst_rsp", 32'(bif.rsp_valid), 32'd0);
    chk("mid_rst_ready", 32'(bif.cmd_ready), 32'd0);
    reset = 1'b0;
    m_rdata = '0;
    @(negedge clk);
    chk("mid_after_ready", 32'(bif.cmd_ready), 32'd1);
    seen = 0;
    repeat (TIMEOUT + 8) begin
      @(negedge clk);
      if (bif.rsp_valid) seen++;
    end
    chk("mid_no_rsp", 32'(seen), 32'd0);

    // random commands
    for (int i = 0; i < 24; i++) begin
      r = int'($urandom_range(0, 9));
      kind = (r < 4) ? K_DTACK : (r < 6) ? K_BERR : (r < 8) ? K_VPA : (r == 8) ? K_NONE : K_BOTH;
      do_xact(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 24'($urandom), 3'($urandom),
              16'($urandom), kind, int'($urandom_range(0, 8)), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
